puzzle_move_unit: RTL and testbench

Move-execution stage of the 8-puzzle solver, sitting directly downstream of the board register file. It accepts the current 36-bit board, the 36-bit goal board and a move direction, then locates the blank tile with a sequential cell scan. It checks move legality, swaps the blank with its neighbour, compares the result against the goal, and presents the new board for write-back through a valid/ready handshake.

---
 rtl/puzzle_move_unit.sv | 177 +++++++++++++++++
 tb/tb_puzzle_move_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/puzzle_move_unit.sv
// puzzle_move_unit: move-execution stage of the 8-puzzle solver.
// Latches a board, goal and direction, scans the nine cells one per cycle
// for the blank, applies the move if legal, compares the result with the
// goal and holds the result until the consumer accepts it.
// Optional feature: define PUZZLE_MOVE_HISTORY_EN to reject a move that
// exactly undoes the previous legal move.
module puzzle_move_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_dir,
    input  logic [35:0]      board_in,
    input  logic [35:0]      goal_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [35:0]      res_board,
    output logic             res_illegal,
    output logic             res_badboard,
    output logic             res_solved,
    output logic [CNT_W-1:0] move_count
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_MOVE, S_RESULT} state_t;

    state_t state_q, state_d;

    logic [35:0]      board_q, goal_q;
    logic [1:0]       dir_q;
    logic [3:0]       idx_q, pos_q;
    logic             bad_q;

    logic [35:0]      res_board_q, res_board_d;
    logic             res_illegal_q, res_illegal_d;
    logic             res_badboard_q, res_badboard_d;
    logic             res_solved_q, res_solved_d;
    logic [CNT_W-1:0] move_count_q, move_count_d;

    logic [3:0]       scan_cell;
    logic             legal;
    logic [3:0]       tgt;
    logic [1:0]       col;

`ifdef PUZZLE_MOVE_HISTORY_EN
    logic             hist_vld_q;
    logic [1:0]       hist_dir_q;
`endif

    // Cell i lives at bits [35-4i -: 4]; cell 0 is the most significant nibble.
    function automatic logic [3:0] cell_get(input logic [35:0] b, input logic [3:0] i);
        logic [35:0] sh;
        sh = b >> (4 * (8 - int'(i)));
        return sh[3:0];
    endfunction

    function automatic logic [35:0] cell_set(input logic [35:0] b, input logic [3:0] i,
                                             input logic [3:0] v);
        int amt;
        amt = 4 * (8 - int'(i));
        return (b & ~(36'hF << amt)) | ({32'd0, v} << amt);
    endfunction

    function automatic logic [1:0] col_of(input logic [3:0] p);
        case (p)
            4'd0, 4'd3, 4'd6: return 2'd0;
            4'd1, 4'd4, 4'd7: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

    assign scan_cell = cell_get(board_q, idx_q);

    // State register; reset discards any in-flight command.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: scan stops at the first blank or after cell 8.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (cmd_valid) state_d = S_SCAN;
            S_SCAN:   if (scan_cell == 4'h0 || idx_q == 4'd8) state_d = S_MOVE;
            S_MOVE:   state_d = S_RESULT;
            S_RESULT: if (res_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        res_valid = (state_q == S_RESULT);
    end

    // Command latch and blank scan; these are reloaded on every acceptance.
    always_ff @(posedge clk) begin
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    board_q <= board_in;
                    goal_q  <= goal_in;
                    dir_q   <= cmd_dir;
                    idx_q   <= 4'd0;
                    bad_q   <= 1'b0;
                end
            end
            S_SCAN: begin
                if (scan_cell == 4'h0)   pos_q <= idx_q;
                else if (idx_q == 4'd8)  bad_q <= 1'b1;
                else                     idx_q <= idx_q + 4'd1;
            end
            default: ;
        endcase
    end

    // Move evaluation: legality, neighbour swap, goal compare, counter.
    always_comb begin
        col   = col_of(pos_q);
        legal = 1'b0;
        tgt   = pos_q;
        case (dir_q)
            2'b00: begin legal = (pos_q >= 4'd3); tgt = pos_q - 4'd3; end
            2'b01: begin legal = (pos_q <= 4'd5); tgt = pos_q + 4'd3; end
            2'b10: begin legal = (col != 2'd0);   tgt = pos_q - 4'd1; end
            default: begin legal = (col != 2'd2); tgt = pos_q + 4'd1; end
        endcase
        if (bad_q) legal = 1'b0;
`ifdef PUZZLE_MOVE_HISTORY_EN
        // Directions pair as 00/01 and 10/11, so the reverse flips bit 0.
        if (hist_vld_q && dir_q == {hist_dir_q[1], ~hist_dir_q[0]}) legal = 1'b0;
`endif
        res_board_d    = legal ? cell_set(cell_set(board_q, pos_q, cell_get(board_q, tgt)), tgt, 4'h0)
                               : board_q;
        res_solved_d   = (res_board_d == goal_q);
        res_illegal_d  = ~legal;
        res_badboard_d = bad_q;
        move_count_d   = (legal && move_count_q != '1) ? move_count_q + CNT_W'(1) : move_count_q;
    end

    // Result registers, loaded once in MOVE and held through RESULT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_board_q    <= '0;
            res_illegal_q  <= 1'b0;
            res_badboard_q <= 1'b0;
            res_solved_q   <= 1'b0;
            move_count_q   <= '0;
`ifdef PUZZLE_MOVE_HISTORY_EN
            hist_vld_q     <= 1'b0;
            hist_dir_q     <= 2'b00;
`endif
        end else if (state_q == S_MOVE) begin
            res_board_q    <= res_board_d;
            res_illegal_q  <= res_illegal_d;
            res_badboard_q <= res_badboard_d;
            res_solved_q   <= res_solved_d;
            move_count_q   <= move_count_d;
`ifdef PUZZLE_MOVE_HISTORY_EN
            if (legal) begin
                hist_vld_q <= 1'b1;
                hist_dir_q <= dir_q;
            end
`endif
        end
    end

    assign res_board    = res_board_q;
    assign res_illegal  = res_illegal_q;
    assign res_badboard = res_badboard_q;
    assign res_solved   = res_solved_q;
    assign move_count   = move_count_q;

endmodule

// File: tb/tb_puzzle_move_unit.sv
// Self-checking bench for puzzle_move_unit with a cell-array reference model.
module tb_puzzle_move_unit;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_dir;
    logic [35:0]      board_in;
    logic [35:0]      goal_in;
    logic             res_valid;
    logic             res_ready;
    logic [35:0]      res_board;
    logic             res_illegal;
    logic             res_badboard;
    logic             res_solved;
    logic [CNT_W-1:0] move_count;

    int checks = 0;
    int failures = 0;

    // Reference-model state
    int   exp_count = 0;
    bit   hist_vld = 1'b0;
    logic [1:0] hist_dir = 2'b00;

    puzzle_move_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .board_in(board_in), .goal_in(goal_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_board(res_board), .res_illegal(res_illegal),
        .res_badboard(res_badboard), .res_solved(res_solved),
        .move_count(move_count)
    );

    always #5 clk = ~clk;

    // Reference model: board as nine cells, move by row/column arithmetic.
    function automatic void model(input logic [35:0] b, input logic [1:0] d,
                                  output logic [35:0] nb, output logic legal,
                                  output logic bad, output int p);
        int c[9];
        int r, cl, t;
        for (int i = 0; i < 9; i++) c[i] = int'((b >> (4 * (8 - i))) & 36'hF);
        p = -1;
        for (int i = 0; i < 9; i++) if (p < 0 && c[i] == 0) p = i;
        bad = (p < 0);
        legal = 1'b0;
        t = 0;
        if (!bad) begin
            r = p / 3;
            cl = p % 3;
            case (d)
                2'd0: begin legal = (r > 0);  t = p - 3; end
                2'd1: begin legal = (r < 2);  t = p + 3; end
                2'd2: begin legal = (cl > 0); t = p - 1; end
                default: begin legal = (cl < 2); t = p + 1; end
            endcase
`ifdef PUZZLE_MOVE_HISTORY_EN
            if (hist_vld && ((d == 2'd0 && hist_dir == 2'd1) || (d == 2'd1 && hist_dir == 2'd0) ||
                             (d == 2'd2 && hist_dir == 2'd3) || (d == 2'd3 && hist_dir == 2'd2)))
                legal = 1'b0;
`endif
            if (legal) begin
                c[p] = c[t];
                c[t] = 0;
            end
        end
        nb = '0;
        for (int i = 0; i < 9; i++) nb = (nb << 4) | 36'(c[i]);
    endfunction

    task automatic model_commit(input logic legal, input logic [1:0] d);
        if (legal) begin
            if (exp_count < (1 << CNT_W) - 1) exp_count++;
`ifdef PUZZLE_MOVE_HISTORY_EN
            hist_vld = 1'b1;
            hist_dir = d;
`endif
        end
    endtask

    task automatic model_reset();
        exp_count = 0;
        hist_vld = 1'b0;
        hist_dir = 2'b00;
    endtask

    // Drive one command; ok=0 if the block never became ready.
    task automatic accept(input logic [35:0] b, input logic [35:0] g, input logic [1:0] d,
                          output bit ok);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 30) begin @(negedge clk); n++; end
        ok = cmd_ready;
        board_in = b; goal_in = g; cmd_dir = d; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        board_in = {4'($urandom), 32'($urandom)};
        goal_in  = {4'($urandom), 32'($urandom)};
        cmd_dir  = 2'($urandom);
    endtask

    // Cycles from acceptance edge to res_valid, -1 if it never came.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!res_valid && lat < 20);
        if (!res_valid) lat = -1;
    endtask

    task automatic consume();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        checks++; if (res_board !== 36'h0) begin failures++; $display("FAIL reset_res_board got=%h exp=0", res_board); end
        checks++; if ({res_illegal, res_badboard, res_solved} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {res_illegal, res_badboard, res_solved}); end
        checks++; if (move_count !== '0) begin failures++; $display("FAIL reset_move_count got=%0d exp=0", move_count); end
    endtask

    // Scripted single move with full result checking.
    task automatic test_move(input string name, input logic [35:0] b, input logic [35:0] g,
                             input logic [1:0] d);
        logic [35:0] nb; logic legal, bad; int p, lat; bit ok;
        model(b, d, nb, legal, bad, p);
        accept(b, g, d, ok);
        checks++; if (!ok) begin failures++; $display("FAIL %s_accept got=0 exp=1", name); end
        wait_result(lat);
        checks++; if (lat != (bad ? 10 : p + 2)) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, bad ? 10 : p + 2); end
        checks++; if (res_board !== nb) begin failures++; $display("FAIL %s_board got=%h exp=%h", name, res_board, nb); end
        checks++; if (res_illegal !== ~legal) begin failures++; $display("FAIL %s_illegal got=%b exp=%b", name, res_illegal, ~legal); end
        checks++; if (res_badboard !== bad) begin failures++; $display("FAIL %s_badboard got=%b exp=%b", name, res_badboard, bad); end
        checks++; if (res_solved !== (nb == g)) begin failures++; $display("FAIL %s_solved got=%b exp=%b", name, res_solved, nb == g); end
        model_commit(legal, d);
        checks++; if (move_count !== CNT_W'(exp_count)) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", name, move_count, exp_count); end
        consume();
    endtask

    task automatic test_backpressure();
        logic [35:0] nb; logic legal, bad; int p, lat; bit ok;
        logic [35:0] b = 36'h123405786;
        model(b, 2'd0, nb, legal, bad, p);
        accept(b, 36'h0, 2'd0, ok);
        wait_result(lat);
        checks++; if (lat != 6) begin failures++; $display("FAIL bp_latency got=%0d exp=6", lat); end
        model_commit(legal, 2'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (res_valid !== 1'b1 || cmd_ready !== 1'b0 || res_board !== nb ||
                          move_count !== CNT_W'(exp_count) || res_illegal !== ~legal) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%b r=%b b=%h exp v=1 r=0 b=%h", i, res_valid, cmd_ready, res_board, nb);
            end
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin failures++; $display("FAIL bp_release got r=%b v=%b exp r=1 v=0", cmd_ready, res_valid); end
        b = 36'h123456708;
        model(b, 2'd3, nb, legal, bad, p);
        cmd_valid = 1'b1; board_in = b; goal_in = 36'h123456780; cmd_dir = 2'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_next_accept got=%b exp=0", cmd_ready); end
        wait_result(lat);
        checks++; if (lat != 9) begin failures++; $display("FAIL bp_next_latency got=%0d exp=9", lat); end
        checks++; if (res_board !== nb || res_solved !== 1'b1) begin failures++; $display("FAIL bp_next_result got=%h/%b exp=%h/1", res_board, res_solved, nb); end
        model_commit(legal, 2'd3);
        consume();
    endtask

    task automatic test_reset_midscan();
        bit ok; bit seen = 1'b0;
        accept(36'h123456780, 36'h0, 2'd0, ok);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        model_reset();
        checks++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin failures++; $display("FAIL midrst_handshake got r=%b v=%b exp r=1 v=0", cmd_ready, res_valid); end
        checks++; if (res_board !== 36'h0 || {res_illegal, res_badboard, res_solved} !== 3'b000) begin failures++; $display("FAIL midrst_result got=%h/%b exp=0/000", res_board, {res_illegal, res_badboard, res_solved}); end
        checks++; if (move_count !== '0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", move_count); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (res_valid) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("FAIL midrst_no_result got=1 exp=0"); end
    endtask

    task automatic test_reversal();
        test_move("rev_right", 36'h123405786, 36'h123456780, 2'd3);
        test_move("rev_left",  36'h123450786, 36'h123405786, 2'd2);
`ifdef PUZZLE_MOVE_HISTORY_EN
        checks++; if (move_count !== CNT_W'(1) || res_illegal !== 1'b1) begin failures++; $display("FAIL rev_hist got cnt=%0d ill=%b exp cnt=1 ill=1", move_count, res_illegal); end
`else
        checks++; if (move_count !== CNT_W'(2) || res_board !== 36'h123405786) begin failures++; $display("FAIL rev_nohist got cnt=%0d b=%h exp cnt=2 b=123405786", move_count, res_board); end
`endif
    endtask

    task automatic test_random();
        int perm[9];
        logic [35:0] b, g, nb; logic legal, bad; int p, k, tmp;
        logic [1:0] d;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 9; i++) perm[i] = i;
            for (int i = 8; i > 0; i--) begin
                k = int'($urandom_range(i, 0));
                tmp = perm[i]; perm[i] = perm[k]; perm[k] = tmp;
            end
            k = int'($urandom_range(7, 0));
            for (int i = 0; i < 9; i++) begin
                if (k == 0 && perm[i] == 0) perm[i] = 9 + int'($urandom_range(6, 0));
                if (k == 1 && i == 8) perm[i] = 0;
            end
            b = '0;
            for (int i = 0; i < 9; i++) b = (b << 4) | 36'(perm[i]);
            d = 2'($urandom);
            model(b, d, nb, legal, bad, p);
            g = ($urandom_range(1, 0) == 1) ? nb : {4'($urandom), 32'($urandom)};
            test_move($sformatf("rand%0d", n), b, g, d);
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_dir = 2'd0; board_in = '0; goal_in = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_move("plan_down",   36'h123450786, 36'h123456780, 2'd1);
        test_move("illegal_up",  36'h023456781, 36'h123456780, 2'd0);
        test_move("badboard",    36'h123456781, 36'h123456780, 2'd1);
        test_move("dup_blank",   36'h103456700, 36'h000000000, 2'd3);
        test_move("left_edge",   36'h123045678, 36'h0, 2'd2);
        test_backpressure();
        test_reset_midscan();
        test_reversal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
